// File: rtl/spy_pkg.sv
// Shared definitions for the spy debug port: register map, ctrl/status
// bit positions and the single-step FSM state encoding.
package spy_pkg;

  localparam logic [3:0] SPY_IR0     = 4'd0;
  localparam logic [3:0] SPY_IR1     = 4'd1;
  localparam logic [3:0] SPY_IR2     = 4'd2;
  localparam logic [3:0] SPY_CTRL    = 4'd3;
  localparam logic [3:0] SPY_STATUS  = 4'd4;
  localparam logic [3:0] SPY_LPC     = 4'd5;
  localparam logic [3:0] SPY_OBUS_LO = 4'd6;
  localparam logic [3:0] SPY_OBUS_HI = 4'd7;

  localparam int CTRL_RUN   = 0;
  localparam int CTRL_STEP  = 1;
  localparam int CTRL_NOOP  = 2;
  localparam int CTRL_DEBUG = 3;

  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_OVERRUN = 2;
  localparam int ST_TIMEOUT = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STEP,
    S_WAIT,
    S_CAP
  } step_state_e;

endpackage

// File: rtl/spy_port_responder_step_fsm.sv
// Single-step sequencer: pulses cpu_step, waits for a fetch_done rising
// edge, then asserts cap_en for one cycle. Optional WAIT timeout under
// SPY_TIMEOUT_EN (limit TIMEOUT_CYC cycles).
// Ports: clk, reset, start, fetch_done -> busy, cpu_step, cap_en, timeout_hit.
module spy_step_fsm
  import spy_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic fetch_done,
  output logic busy,
  output logic cpu_step,
  output logic cap_en,
  output logic timeout_hit
);

  step_state_e state, state_nx;
  logic        fetch_q;
  logic        fetch_rise;
  logic        expired;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      fetch_q <= 1'b0;
    end else begin
      state   <= state_nx;
      fetch_q <= fetch_done;
    end
  end

  assign fetch_rise = fetch_done & ~fetch_q;

`ifdef SPY_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt;

  // Counts cycles spent in WAIT; restarts on every entry.
  always_ff @(posedge clk) begin
    if (reset || state != S_WAIT) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = (state == S_WAIT) && !fetch_rise &&
                   (cnt == CW'(TIMEOUT_CYC - 1));
`else
  assign expired = 1'b0;
`endif

  always_comb begin
    state_nx    = state;
    cpu_step    = 1'b0;
    cap_en      = 1'b0;
    timeout_hit = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) state_nx = S_STEP;
      end
      S_STEP: begin
        cpu_step = 1'b1;
        state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (fetch_rise) begin
          state_nx = S_CAP;
        end else if (expired) begin
          state_nx    = S_IDLE;
          timeout_hit = 1'b1;
        end
      end
      S_CAP: begin
        cap_en   = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

endmodule

// File: rtl/spy_port_responder.sv
// CPU side of the spy bus: IR/ctrl register file, status/PC/OBUS read mux.
// Ports: dbread/dbwrite/eadr/spy_din/spy_dout host side; ir, ir_sel,
// cpu_run, cpu_step, cpu_noop, fetch_done, obus, lpc core side.
// Optional macro SPY_TIMEOUT_EN enables the WAIT timeout.
module spy_port_responder
  import spy_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dbread,
  input  logic        dbwrite,
  input  logic [3:0]  eadr,
  input  logic [15:0] spy_din,
  output logic [15:0] spy_dout,
  output logic [47:0] ir,
  output logic        ir_sel,
  output logic        cpu_run,
  output logic        cpu_step,
  output logic        cpu_noop,
  input  logic        fetch_done,
  input  logic [31:0] obus,
  input  logic [13:0] lpc
);

  logic [15:0] ctrl;
  logic [31:0] obus_snap;
  logic        step_done;
  logic        overrun;
  logic        timeout;
  logic        busy;
  logic        cap_en;
  logic        timeout_hit;
  logic        wr_ctrl;
  logic        rd_status;
  logic        start;
  logic [15:0] rd_data;

  assign wr_ctrl   = dbwrite && (eadr == SPY_CTRL);
  assign rd_status = dbread && (eadr == SPY_STATUS);
  // Run bit wins over step: a step only launches from a run=0 write.
  assign start     = wr_ctrl && !busy &&
                     spy_din[CTRL_STEP] && !spy_din[CTRL_RUN];

  spy_step_fsm #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_fsm (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .fetch_done  (fetch_done),
    .busy        (busy),
    .cpu_step    (cpu_step),
    .cap_en      (cap_en),
    .timeout_hit (timeout_hit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      ir        <= '0;
      ctrl      <= '0;
      obus_snap <= '0;
      step_done <= 1'b0;
      overrun   <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      if (dbwrite) begin
        case (eadr)
          SPY_IR0: ir[15:0]  <= spy_din;
          SPY_IR1: ir[31:16] <= spy_din;
          SPY_IR2: ir[47:32] <= spy_din;
          default: ;
        endcase
      end
      if (wr_ctrl && !busy) ctrl <= spy_din;
      if (cap_en) obus_snap <= obus;
      // New events win over a same-cycle status read clear.
      step_done <= cap_en | (step_done & ~rd_status);
      overrun   <= (wr_ctrl & busy) | (overrun & ~rd_status);
      timeout   <= timeout_hit | (timeout & ~rd_status);
    end
  end

  always_comb begin
    rd_data = '0;
    case (eadr)
      SPY_IR0:     rd_data = ir[15:0];
      SPY_IR1:     rd_data = ir[31:16];
      SPY_IR2:     rd_data = ir[47:32];
      SPY_CTRL:    rd_data = ctrl;
      SPY_STATUS:  rd_data = {12'b0, timeout, overrun, step_done, busy};
      SPY_LPC:     rd_data = {2'b0, lpc};
      SPY_OBUS_LO: rd_data = obus_snap[15:0];
      SPY_OBUS_HI: rd_data = obus_snap[31:16];
      default:     rd_data = '0;
    endcase
  end

  assign spy_dout = dbread ? rd_data : 16'h0000;
  assign cpu_run  = ctrl[CTRL_RUN];
  assign cpu_noop = ctrl[CTRL_NOOP];
  assign ir_sel   = ctrl[CTRL_DEBUG];

endmodule

// File: tb/tb_spy_port_responder.sv
// Scoreboard bench for spy_port_responder: random host traffic checked
// against a register-level model of the spy port.
module tb_spy_port_responder;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        dbread = 1'b0;
  logic        dbwrite = 1'b0;
  logic [3:0]  eadr = '0;
  logic [15:0] spy_din = '0;
  logic [15:0] spy_dout;
  logic [47:0] ir;
  logic        ir_sel, cpu_run, cpu_step, cpu_noop;
  logic        fetch_done = 1'b0;
  logic [31:0] obus = '0;
  logic [13:0] lpc = '0;

  int total = 0;
  int bad = 0;
  int step_cnt = 0;
  int exp_steps = 0;

  logic [15:0] exp_q[$];
  string       tag_q[$];

  logic [47:0] m_irw;
  logic [15:0] m_ctrl;
  logic [31:0] m_snap;
  bit          m_busy, m_done, m_ovr, m_to;

  always #5 clk = ~clk;

  spy_port_responder #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .dbread(dbread), .dbwrite(dbwrite),
    .eadr(eadr), .spy_din(spy_din), .spy_dout(spy_dout), .ir(ir),
    .ir_sel(ir_sel), .cpu_run(cpu_run), .cpu_step(cpu_step),
    .cpu_noop(cpu_noop), .fetch_done(fetch_done), .obus(obus), .lpc(lpc)
  );

  function automatic void chk(string n, logic [63:0] got,
                              logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", n, got, exp);
    end
  endfunction

  // Monitor: counts step pulses and checks every read cycle.
  always @(negedge clk) begin
    if (cpu_step) step_cnt++;
    if (dbread) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rd_unexpected got=%0h exp=none", spy_dout);
      end else begin
        chk(tag_q.pop_front(), spy_dout, exp_q.pop_front());
      end
    end
  end

  function automatic void m_reset();
    m_irw = '0; m_ctrl = '0; m_snap = '0;
    m_busy = 0; m_done = 0; m_ovr = 0; m_to = 0;
  endfunction

  function automatic logic [15:0] m_read(logic [3:0] a);
    logic [15:0] v;
    case (a)
      4'd0, 4'd1, 4'd2: v = m_irw[16*int'(a) +: 16];
      4'd3: v = m_ctrl;
      4'd4: begin
        v = {12'b0, m_to, m_ovr, m_done, m_busy};
        m_to = 0; m_ovr = 0; m_done = 0;
      end
      4'd5: v = {2'b0, lpc};
      4'd6: v = m_snap[15:0];
      4'd7: v = m_snap[31:16];
      default: v = '0;
    endcase
    return v;
  endfunction

  function automatic void m_write(logic [3:0] a, logic [15:0] d);
    if (a <= 4'd2) begin
      m_irw[16*int'(a) +: 16] = d;
    end else if (a == 4'd3) begin
      if (m_busy) m_ovr = 1;
      else begin
        m_ctrl = d;
        if (d[1] && !d[0]) begin
          m_busy = 1;
          exp_steps++;
        end
      end
    end
  endfunction

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(logic [3:0] a, logic [15:0] d);
    m_write(a, d);
    dbwrite = 1; eadr = a; spy_din = d;
    idle(1);
    dbwrite = 0;
  endtask

  task automatic rd(logic [3:0] a, string n);
    exp_q.push_back(m_read(a));
    tag_q.push_back(n);
    dbread = 1; eadr = a;
    idle(1);
    dbread = 0;
  endtask

  task automatic rdwr(logic [3:0] a, logic [15:0] d, string n);
    exp_q.push_back(m_read(a));
    tag_q.push_back(n);
    m_write(a, d);
    dbread = 1; dbwrite = 1; eadr = a; spy_din = d;
    idle(1);
    dbread = 0; dbwrite = 0;
  endtask

  task automatic chk_outs(string n);
    chk({n, "_ir"}, ir, m_irw);
    chk({n, "_run"}, cpu_run, m_ctrl[0]);
    chk({n, "_noop"}, cpu_noop, m_ctrl[2]);
    chk({n, "_irsel"}, ir_sel, m_ctrl[3]);
    chk({n, "_step"}, cpu_step, 0);
    chk({n, "_nsteps"}, step_cnt, exp_steps);
  endtask

  task automatic do_step(logic [15:0] c, int dly, bit collide);
    int s0;
    logic [15:0] c2;
    obus = $urandom;
    s0 = step_cnt;
    wr(3, c);
    idle(dly);
    rd(4, "st_busy");
    if (collide) begin
      c2 = 16'($urandom);
      c2[1] = 1'b1;
      c2[0] = 1'b0;
      wr(3, c2);
      rd(3, "ctrl_kept");
    end
    fetch_done = 1;
    idle(1);
    fetch_done = 0;
    idle(2);
    m_busy = 0;
    m_done = 1;
    m_snap = obus;
    chk("step_pulses", step_cnt - s0, 1);
    chk_outs("post_step");
  endtask

  initial begin
    logic [15:0] d;
    logic [15:0] c;
    logic [3:0]  a;
    int s0;
    m_reset();
    lpc = 14'($urandom);
    idle(3);
    reset = 0;
    idle(1);
    chk_outs("reset");
    for (int i = 0; i < 8; i++) rd(4'(i), "rst_rd");

    wr(2, 16'h0000); wr(1, 16'h0000); wr(0, 16'hA800);
    rd(0, "ir0"); rd(1, "ir1"); rd(2, "ir2");
    chk("ir_a800", ir, 48'h00000000A800);

    do_step(16'h000A, 5, 1'b0);
    rd(7, "snap_hi"); rd(6, "snap_lo");
    rd(4, "st_done"); rd(4, "st_clr");

    do_step(16'h0006, 3, 1'b1);
    rd(4, "st_ovr"); rd(3, "ctrl_rd");

    s0 = step_cnt;
    wr(3, 16'h0003);
    idle(3);
    chk("run_nostep", step_cnt - s0, 0);
    rd(4, "run_st");
    chk_outs("run");
    wr(3, 16'h0000);
    chk_outs("stop");

    for (int i = 0; i < 60; i++) begin
      lpc = 14'($urandom);
      case ($urandom_range(0, 4))
        0: wr(4'($urandom_range(0, 2)), 16'($urandom));
        1: rd(4'($urandom_range(0, 15)), "rnd_rd");
        2: begin
          a = 4'($urandom_range(0, 15));
          if (a == 4'd3) a = 4'd0;
          rdwr(a, 16'($urandom), "rnd_rdwr");
        end
        3: begin
          d = 16'($urandom);
          if (d[1] && !d[0]) d[0] = 1'b1;
          wr(3, d);
        end
        default: begin
          c = 16'($urandom);
          c[1] = 1'b1;
          c[0] = 1'b0;
          do_step(c, $urandom_range(2, 6), 1'($urandom));
        end
      endcase
      chk_outs("rnd");
    end
    rd(4, "rnd_st");

`ifdef SPY_TIMEOUT_EN
    obus = $urandom;
    wr(3, 16'h0002);
    idle(TO + 4);
    m_busy = 0;
    m_to = 1;
    rd(4, "to_st"); rd(6, "to_lo"); rd(7, "to_hi");
`endif

    obus = $urandom;
    wr(3, 16'h0002);
    idle(3);
    reset = 1;
    idle(1);
    reset = 0;
    m_reset();
    exp_steps = step_cnt;
    chk_outs("rst_wait");
    fetch_done = 1;
    idle(1);
    fetch_done = 0;
    idle(3);
    rd(4, "rst_st"); rd(6, "rst_lo"); rd(7, "rst_hi");

    idle(2);
    chk("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spy_port_responder.md
# spy_port_responder

CPU-side end of the spy debug bus. Decodes dbread/dbwrite strobes and a 4-bit register address from the host spy driver into a 48-bit debug instruction register, a clock-control register, and read-back of status, PC and a latched OBUS snapshot. Runs a single-step FSM that issues one CPU step and waits for the prefetch-complete indication. Sits between the spy host logic and the CADR core's clock and IR-select controls.

## Interface
- TIMEOUT_CYC, default 1024: WAIT-state cycle limit before the step is abandoned; used only with SPY_TIMEOUT_EN.
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- dbread  in  1  read strobe, one cycle
- dbwrite  in  1  write strobe, one cycle
- eadr  in  4  spy register address
- spy_din  in  16  write data, valid with dbwrite
- spy_dout  out  16  read data, valid in the dbread cycle
- ir  out  48  debug instruction register
- ir_sel  out  1  core executes ir instead of I-mem output
- cpu_run  out  1  free-run enable, level
- cpu_step  out  1  one-cycle step request
- cpu_noop  out  1  step executes as no-op, level, qualifies cpu_step
- fetch_done  in  1  core prefetch indication; step completes on its rising edge
- obus  in  32  core output bus
- lpc  in  14  core last PC

## Operation
Register map (octal address, W/R):
- 0/1/2 W,R: ir[15:0], ir[31:16], ir[47:32].
- 3 W: bit0 run, bit1 step, bit2 noop, bit3 debug (drives ir_sel). R: last written value.
- 4 R: bit0 busy, bit1 step_done (sticky), bit2 overrun (sticky), bit3 timeout (sticky). Any read of 4 clears the sticky bits in the following cycle.
- 5 R: {2'b0, lpc}.
- 6/7 R: obus_snap[15:0], obus_snap[31:16].
- All other addresses: write ignored, read 0.

Step FSM states:
- IDLE: on a reg-3 write with bit1=1 and bit0=0 -> STEP.
- STEP: cpu_step=1 for exactly one cycle -> WAIT.
- WAIT: on fetch_done rising edge (fetch_done=1, previous sample 0) -> CAP.
- CAP: obus_snap<=obus, step_done<=1 -> IDLE.
- busy=1 in STEP, WAIT and CAP.

Rules:
- A reg-3 write while busy=1 is discarded entirely (reg 3 unchanged) and sets overrun.
- A reg-3 write with bit0=1 sets cpu_run and never starts a step, even if bit1=1.
- A reg-3 write of 0 clears run, noop and debug.
- cpu_noop=ctrl[2] and ir_sel=ctrl[3], both level outputs taken directly from reg 3.
- IR writes are accepted in any state.
- dbread and dbwrite asserted in the same cycle: the write takes effect; spy_dout shows the pre-write value.

## Timing
- Reset: ir=0, ctrl=0, obus_snap=0, all sticky bits=0, FSM=IDLE, spy_dout=0, cpu_step=0, cpu_run=0, cpu_noop=0, ir_sel=0.
- Writes take effect at the posedge that samples dbwrite; the new value is visible on outputs the next cycle.
- spy_dout is a combinational mux of registered sources selected by eadr, gated by dbread, so the host can sample it at the posedge where dbread=1. spy_dout=0 when dbread=0.
- Step latency: write edge -> cpu_step high the next cycle.
- Step done: fetch_done rising edge seen in WAIT -> obus_snap and step_done update 2 cycles later.
- reset during WAIT: FSM returns to IDLE and no capture occurs.

## Configuration
- SPY_TIMEOUT_EN defined: WAIT runs a counter. If it reaches TIMEOUT_CYC without a fetch_done edge, the FSM returns to IDLE, sets timeout, and leaves obus_snap unchanged.
- SPY_TIMEOUT_EN undefined: WAIT has no limit; status bit3 reads 0.

## Structure
- Package spy_pkg: register-address constants (SPY_IR0..SPY_OBUS_HI), ctrl bit positions, status bit positions, FSM state enum.
- Sub-module spy_step_fsm: edge detect, state register, timeout counter, capture enable.
- Top level holds the register file and read mux.

## Test plan
- Write regs 2/1/0 = 0x0000/0x0000/0xA800; read 0,1,2 -> 0xA800,0x0000,0x0000; ir=48'h00000000A800.
- Write reg3=0x000A, obus=0x12345678, pulse fetch_done 5 cycles later -> cpu_step single pulse; reg7=0x1234, reg6=0x5678; reg4 bit1=1, and reads 0 on the next read.
- Second reg3 write while in WAIT -> overrun=1, no second cpu_step, reg3 unchanged.
- Write reg3=0x0001 -> cpu_run=1, no cpu_step; write 0 -> cpu_run=0, ir_sel=0.
- SPY_TIMEOUT_EN, TIMEOUT_CYC=16, no fetch_done -> busy drops after 16 cycles, timeout=1, obus_snap unchanged.
- Assert reset during WAIT -> all outputs 0; a later fetch_done pulse causes no capture.
